// File: rtl/exu_div_ctl64.sv
// exu_div_ctl64: RV64 restoring divider, one quotient bit per cycle.
// Define DIV_FAST_SMALLNUM_EN to build the small-operand fast path.
package exu_div_pkg;
    typedef struct packed {
        logic valid;
        logic unsign;
        logic rem;
    } div_pkt_t;
endpackage

module exu_div_ctl64
    import exu_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_l,
    input  logic        active_clk,
    input  logic        scan_mode,
    input  logic        dec_tlu_fast_div_disable,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  div_pkt_t    dp,
    input  logic        flush_lower,
    output logic        valid_ff_e1,
    output logic        finish_early,
    output logic        finish,
    output logic        div_stall,
    output logic [63:0] out
);
    typedef enum logic [1:0] {IDLE, E1, RUN, DONE} state_e;

    state_e      state_q, state_d;
    logic [63:0] a_q, b_q, r_q, out_q;
    logic [5:0]  cnt_q;
    logic        rem_q, sa_q, sb_q, valid_q;

    logic        fast, accept, in_e1, last, neg_q;
    logic [63:0] abs_a, abs_b, step_a, step_b, res_norm, res_fast;
    logic [64:0] r_sh, r_sub;
    logic [63:0] step_r;

`ifdef DIV_FAST_SMALLNUM_EN
    logic        unused_ok;
    logic [3:0]  fq, fr;
    assign fq = a_q[3:0] / b_q[3:0];
    assign fr = a_q[3:0] % b_q[3:0];
    assign fast = in_e1 & ~|a_q[63:4] & ~|b_q[63:4] & |b_q[3:0]
                & ~dec_tlu_fast_div_disable;
    assign res_fast = rem_q ? {60'd0, fr} : {60'd0, fq};
    assign unused_ok = &{1'b0, active_clk, scan_mode};
`else
    logic        unused_ok;
    assign fast = 1'b0;
    assign res_fast = '0;
    assign unused_ok = &{1'b0, active_clk, scan_mode,
                         dec_tlu_fast_div_disable};
`endif

    assign in_e1 = (state_q == E1);
    assign last = (state_q == RUN) && (cnt_q == 6'd63);
    assign accept = dp.valid & ~flush_lower
                  & ((state_q == IDLE) | (state_q == DONE) | fast);

    // E1 takes absolute values and performs the first iteration.
    always_comb begin
        abs_a = sa_q ? (~a_q + 64'd1) : a_q;
        abs_b = sb_q ? (~b_q + 64'd1) : b_q;
        step_b = in_e1 ? abs_b : b_q;
        r_sh = in_e1 ? {64'd0, abs_a[63]} : {r_q, a_q[63]};
        r_sub = r_sh - {1'b0, step_b};
        step_r = r_sub[64] ? r_sh[63:0] : r_sub[63:0];
        step_a = in_e1 ? {abs_a[62:0], ~r_sub[64]}
                       : {a_q[62:0], ~r_sub[64]};
        neg_q = (sa_q ^ sb_q) & (|b_q);
        if (rem_q)
            res_norm = sa_q ? (~step_r + 64'd1) : step_r;
        else
            res_norm = neg_q ? (~step_a + 64'd1) : step_a;
    end

    always_ff @(posedge clk) begin
        if (rst_l) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = E1;
            E1:      state_d = fast ? (accept ? E1 : IDLE) : RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = accept ? E1 : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_lower) state_d = IDLE;
        finish_early = fast & ~flush_lower;
        finish = finish_early | (state_q == DONE);
        div_stall = (in_e1 & ~fast) | (state_q == RUN);
        out = finish_early ? res_fast : out_q;
        valid_ff_e1 = valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst_l) begin
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= accept;
            if (flush_lower) begin
                cnt_q <= '0;
            end else begin
                if (finish_early)
                    out_q <= res_fast;
                else if (last)
                    out_q <= res_norm;
                if (accept) begin
                    a_q   <= dividend;
                    b_q   <= divisor;
                    r_q   <= '0;
                    cnt_q <= '0;
                    rem_q <= dp.rem;
                    sa_q  <= ~dp.unsign & dividend[63];
                    sb_q  <= ~dp.unsign & divisor[63];
                end else if ((in_e1 & ~fast) | (state_q == RUN)) begin
                    a_q   <= step_a;
                    b_q   <= step_b;
                    r_q   <= step_r;
                    cnt_q <= in_e1 ? 6'd1 : cnt_q + 6'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_exu_div_ctl64.sv
// Directed bench for exu_div_ctl64: reset, iterative and fast paths,
// signed corner cases, divide by zero and flush.
module tb_exu_div_ctl64;
    import exu_div_pkg::*;

`ifdef DIV_FAST_SMALLNUM_EN
    localparam logic FAST_EN = 1'b1;
`else
    localparam logic FAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic        fdis = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    div_pkt_t    dp = '0;
    logic        flush_lower = 1'b0;
    logic        valid_ff_e1, finish_early, finish, div_stall;
    logic [63:0] out;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    exu_div_ctl64 dut (
        .clk                      (clk),
        .rst_l                    (rst_l),
        .active_clk               (clk),
        .scan_mode                (1'b0),
        .dec_tlu_fast_div_disable (fdis),
        .dividend                 (dividend),
        .divisor                  (divisor),
        .dp                       (dp),
        .flush_lower              (flush_lower),
        .valid_ff_e1              (valid_ff_e1),
        .finish_early             (finish_early),
        .finish                   (finish),
        .div_stall                (div_stall),
        .out                      (out)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a,
                          input logic [63:0] b, input logic u,
                          input logic r, input logic fst,
                          input logic [63:0] exp);
        int c;
        @(negedge clk);
        dividend = a;
        divisor = b;
        dp = {1'b1, u, r};
        @(negedge clk);
        dp = '0;
        chk({tag, "/vld_e1"}, 64'(valid_ff_e1), 64'd1);
        if (fst) begin
            chk({tag, "/fin_early"}, 64'(finish_early), 64'd1);
            chk({tag, "/fin"}, 64'(finish), 64'd1);
            chk({tag, "/stall"}, 64'(div_stall), 64'd0);
            chk({tag, "/out"}, out, exp);
        end else begin
            chk({tag, "/stall1"}, 64'(div_stall), 64'd1);
            c = 1;
            while (div_stall === 1'b1 && c < 200) begin
                @(negedge clk);
                c++;
            end
            chk({tag, "/cycles"}, 64'(c), 64'd65);
            chk({tag, "/fin"}, 64'(finish), 64'd1);
            chk({tag, "/fin_early"}, 64'(finish_early), 64'd0);
            chk({tag, "/out"}, out, exp);
        end
        @(negedge clk);
        chk({tag, "/fin_drop"}, 64'(finish), 64'd0);
        chk({tag, "/vld_drop"}, 64'(valid_ff_e1), 64'd0);
        chk({tag, "/held"}, out, exp);
    endtask

    initial begin
        int nfin;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        chk("rst/out", out, 64'd0);
        chk("rst/fin", 64'(finish), 64'd0);
        chk("rst/fin_early", 64'(finish_early), 64'd0);
        chk("rst/stall", 64'(div_stall), 64'd0);
        chk("rst/vld", 64'(valid_ff_e1), 64'd0);

        run_op("divu", 64'h7D0, 64'h3, 1'b1, 1'b0, 1'b0, 64'h29A);
        run_op("remu", 64'h7D0, 64'h3, 1'b1, 1'b1, 1'b0, 64'h2);
        run_op("div_fast", 64'hE, 64'h3, 1'b0, 1'b0, FAST_EN, 64'h4);
        fdis = 1'b1;
        run_op("div_fdis", 64'hE, 64'h3, 1'b0, 1'b0, 1'b0, 64'h4);
        fdis = 1'b0;
        run_op("div_neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 1'b0, 1'b0,
               1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem_neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 1'b0, 1'b1,
               1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000);
        run_op("rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b0, 1'b1, 1'b0, 64'h0);
        run_op("div_z", 64'h5, 64'h0, 1'b0, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remu_z", 64'h5, 64'h0, 1'b1, 1'b1, 1'b0, 64'h5);

        @(negedge clk);
        dividend = 64'h1234;
        divisor = 64'h7;
        dp = 3'b110;
        @(negedge clk);
        dp = '0;
        repeat (9) @(negedge clk);
        chk("flush/stall_t10", 64'(div_stall), 64'd1);
        flush_lower = 1'b1;
        @(negedge clk);
        flush_lower = 1'b0;
        chk("flush/stall_t11", 64'(div_stall), 64'd0);
        chk("flush/fin_t11", 64'(finish), 64'd0);
        chk("flush/out_kept", out, 64'h5);
        nfin = 0;
        repeat (70) begin
            @(negedge clk);
            if (finish === 1'b1) nfin++;
        end
        chk("flush/no_fin", 64'(nfin), 64'd0);
        run_op("divu_post", 64'h9, 64'h4, 1'b1, 1'b0, FAST_EN, 64'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/exu_div_ctl64.md
# exu_div_ctl64

64-bit integer divide unit for the execute stage of the RV64 core. It accepts one divide/remainder request per operation from decode and iterates one quotient bit per cycle. A fast path returns results for small operands early. While an operation is in flight it stalls the pipe through `div_stall`, and it signals completion with `finish`.

## Interface
- Parameters: none; `XLEN` is fixed at 64.
- `clk` input 1: the single clock; all flops are on its rising edge.
- `rst_l` input 1: synchronous, active-high reset (1 = reset).
- `active_clk` input 1: level-1 active clock; must equal `clk`; unused internally.
- `scan_mode` input 1: unused; no clock gating.
- `dec_tlu_fast_div_disable` input 1: 1 disables the small-number fast path.
- `dividend` input 64: numerator; sampled when `dp.valid`=1.
- `divisor` input 64: denominator; sampled when `dp.valid`=1.
- `dp` input 3: `div_pkt_t` packed {valid, unsign, rem}.
  - valid starts an operation.
  - unsign=1 selects DIVU/REMU.
  - rem=1 returns the remainder instead of the quotient.
- `flush_lower` input 1: cancels any operation, pending or running.
- `valid_ff_e1` output 1: registered `dp.valid`.
- `finish_early` output 1: fast-path completion pulse.
- `finish` output 1: completion pulse, fast or normal.
- `div_stall` output 1: an iterative divide is running.
- `out` output 64: result; valid when `finish`=1 and held until the next completion.

## Operation
- Reset: all outputs are 0; counter, state and operand registers are cleared.
- Start: on a rising edge with `dp.valid`=1 and no `flush_lower`, register the operands, unsign, rem and `valid_ff_e1`=1.
- Operand preparation: when signed, take absolute values of both operands.
- Division: restoring unsigned division, 64 iterations, one quotient bit per cycle. A 65-bit partial remainder and a 6-bit counter are used.
- Sign fixup (signed only):
  - Negate the quotient when operand signs differ and divisor≠0.
  - The remainder takes the dividend's sign.
- Divide by zero: quotient = all ones, remainder = dividend. This holds in both signed and unsigned modes.
- Signed overflow (0x8000_0000_0000_0000 / −1): quotient = dividend, remainder = 0.
- Fast path: taken when dividend[63:4]=0, divisor[63:4]=0, divisor≠0 and `dec_tlu_fast_div_disable`=0. The result is computed combinationally and no iteration occurs.
- A `dp.valid` while busy is ignored; decode guarantees this does not happen.
- `flush_lower`=1 synchronously clears `valid_ff_e1`, the running state and the counter.
  - No `finish` is produced for the flushed operation.
  - `out` keeps its previous value.
  - Flush takes priority over a simultaneous `dp.valid`; that request is dropped.
- Reset mid-operation aborts the operation the same way as a flush, and also clears `out`.
- States:
  - IDLE → E1 on `dp.valid`.
  - E1 → IDLE (fast path) or E1 → RUN.
  - RUN → DONE when the counter reaches 63.
  - DONE → IDLE.
  - Flush or reset from any state → IDLE.

## Timing
- Cycle T: `dp.valid`=1. Cycle T+1: `valid_ff_e1`=1 for exactly one cycle.
- Fast path: `finish_early`=`finish`=1 in T+1 with `out` valid. `div_stall` stays 0.
- Normal path:
  - `div_stall`=1 in cycles T+1..T+64.
  - `finish`=1 for one cycle in T+65 with `out` valid; `div_stall`=0 in T+65.
  - `finish_early` stays 0.
- A new `dp.valid` is accepted in the `finish` cycle; back-to-back operations are allowed.

## Configuration
- `DIV_FAST_SMALLNUM_EN` defined: the fast path is built as described.
- `DIV_FAST_SMALLNUM_EN` undefined: `finish_early` is tied 0, `dec_tlu_fast_div_disable` is ignored, and every operation takes the 65-cycle path.

## Test plan
- Reset high for 10 cycles, then low → all outputs 0. Then DIVU 0x7D0/0x3 with `dp.valid` at T → `div_stall` high T+1..T+64, `finish` at T+65, `out`=0x29A.
- REMU 0x7D0/0x3 → `out`=0x2 at T+65.
- Fast path:
  - Enabled: DIV 0xE/0x3 → `finish_early`=`finish`=1 at T+1, `out`=0x4.
  - Same operation with `dec_tlu_fast_div_disable`=1 → `finish` at T+65.
- Signed edge cases:
  - DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD.
  - REM −7/2 → 0xFFFF_FFFF_FFFF_FFFF.
  - DIV 0x8000_0000_0000_0000/−1 → 0x8000_0000_0000_0000.
  - REM of the same operands → 0.
- Divide by zero:
  - DIV 5/0 → all ones.
  - REMU 5/0 → 5.
- Flush: `flush_lower` at T+10 of a running divide → `div_stall` low at T+11, no `finish`. A following DIVU 9/4 completes normally with `out`=2.
